// File: rtl/zebra_pkg.sv
// Shared pixel encodings and scheduler state type for the zebra detection pipeline.
// Used by the scheduler, its BRAM port mux and zebra_crossing_detector.
package zebra_pkg;

    localparam logic [1:0] PIX_BG      = 2'b00;
    localparam logic [1:0] PIX_WHITE   = 2'b01;
    localparam logic [1:0] PIX_VISITED = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SETTLE,
        DETECT,
        DONE
    } sched_state_t;

endpackage

// File: rtl/zebra_bram_port_mux.sv
// Selects which client drives the shared image BRAM: the loader in LOAD, the detector in DETECT.
// Purely combinational, zero latency; no flow control of its own.
module zebra_bram_port_mux
    import zebra_pkg::*;
#(
    parameter int AW = 19
) (
    input  sched_state_t      state,
    input  logic [AW-1:0]     wr_cnt,
    input  logic              pix_valid,
    input  logic              pix_data,
    input  logic [AW-1:0]     det_bram_addr,
    input  logic [AW-1:0]     det_mark_addr,
    input  logic              det_mark_we,
    output logic [AW-1:0]     bram_raddr,
    output logic [AW-1:0]     bram_waddr,
    output logic [1:0]        bram_wdata,
    output logic              bram_we
);

    always_comb begin
        bram_raddr = '0;
        bram_waddr = '0;
        bram_wdata = PIX_BG;
        bram_we    = 1'b0;
        case (state)
            // pix_ready is high throughout LOAD, so valid alone marks a transfer
            LOAD: begin
                bram_we    = pix_valid;
                bram_waddr = wr_cnt;
                bram_wdata = pix_data ? PIX_WHITE : PIX_BG;
            end
            DETECT: begin
                bram_raddr = det_bram_addr;
                bram_we    = det_mark_we;
                bram_waddr = det_mark_addr;
                bram_wdata = PIX_VISITED;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/zebra_frame_scheduler.sv
// Runs one load+detect pass per start: streams a frame into the BRAM, arms the detector, latches its verdict.
// Pixel writes are zero-latency; loader is backpressured (pix_ready=0) outside LOAD; DETECT bounded by a timeout.
module zebra_frame_scheduler
    import zebra_pkg::*;
#(
    parameter int  IMG_WIDTH      = 640,
    parameter int  IMG_HEIGHT     = 480,
    parameter int  TIMEOUT_CYCLES = 10_000_000,
    localparam int TOTAL          = IMG_WIDTH * IMG_HEIGHT,
    localparam int AW             = $clog2(TOTAL),
    localparam int TW             = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic           abort,
    input  logic           pix_valid,
    input  logic           pix_data,
    output logic           pix_ready,
    output logic           det_valid_to_read,
    input  logic           det_detection_valid,
    input  logic           det_crossing,
    input  logic [7:0]     det_stripe_count,
    input  logic [AW-1:0]  det_bram_addr,
    input  logic [AW-1:0]  det_mark_addr,
    input  logic           det_mark_we,
    output logic [AW-1:0]  bram_raddr,
    output logic [AW-1:0]  bram_waddr,
    output logic [1:0]     bram_wdata,
    output logic           bram_we,
    output logic           busy,
    output logic           result_valid,
    output logic           crossing_detected,
    output logic [7:0]     stripe_count,
    output logic           timed_out
);

    localparam logic [AW-1:0] LAST_ADDR = AW'(TOTAL - 1);
    localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);

    sched_state_t  state, state_nxt;
    logic [AW-1:0] wr_cnt;
    logic [TW-1:0] to_cnt;

    always_comb begin
        state_nxt         = state;
        pix_ready         = 1'b0;
        det_valid_to_read = 1'b0;
        result_valid      = 1'b0;
        busy              = (state != IDLE);
        case (state)
            IDLE:   if (start) state_nxt = LOAD;
            LOAD: begin
                pix_ready = 1'b1;
                if (pix_valid && wr_cnt == LAST_ADDR) state_nxt = SETTLE;
            end
            SETTLE: state_nxt = DETECT;
            DETECT: begin
                det_valid_to_read = 1'b1;
                if (det_detection_valid || to_cnt == TO_LAST) state_nxt = DONE;
            end
            DONE: begin
                result_valid = 1'b1;
                state_nxt    = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (abort) state_nxt = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state             <= IDLE;
            wr_cnt            <= '0;
            to_cnt            <= '0;
            crossing_detected <= 1'b0;
            stripe_count      <= '0;
            timed_out         <= 1'b0;
        end else begin
            state <= state_nxt;

            // wr_cnt parks on the last address; SETTLE clears it for the next pass
            if (abort || state != LOAD)
                wr_cnt <= '0;
            else if (pix_valid && wr_cnt != LAST_ADDR)
                wr_cnt <= wr_cnt + AW'(1);

            if (abort || state != DETECT)
                to_cnt <= '0;
            else
                to_cnt <= to_cnt + TW'(1);

            // a detection arriving on the timeout cycle takes precedence
            if (!abort && state == DETECT) begin
                if (det_detection_valid) begin
                    crossing_detected <= det_crossing;
                    stripe_count      <= det_stripe_count;
                    timed_out         <= 1'b0;
                end else if (to_cnt == TO_LAST) begin
                    crossing_detected <= 1'b0;
                    stripe_count      <= '0;
                    timed_out         <= 1'b1;
                end
            end
        end
    end

    zebra_bram_port_mux #(
        .AW (AW)
    ) u_port_mux (
        .state         (state),
        .wr_cnt        (wr_cnt),
        .pix_valid     (pix_valid),
        .pix_data      (pix_data),
        .det_bram_addr (det_bram_addr),
        .det_mark_addr (det_mark_addr),
        .det_mark_we   (det_mark_we),
        .bram_raddr    (bram_raddr),
        .bram_waddr    (bram_waddr),
        .bram_wdata    (bram_wdata),
        .bram_we       (bram_we)
    );

endmodule

// File: tb/tb_zebra_frame_scheduler.sv
// Directed and randomized passes for zebra_frame_scheduler on a 4x4 frame with a 50-cycle timeout.
module tb_zebra_frame_scheduler;
    import zebra_pkg::*;

    localparam int W     = 4;
    localparam int H     = 4;
    localparam int TMO   = 50;
    localparam int TOTAL = W * H;
    localparam int AW    = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          pix_valid = 1'b0;
    logic          pix_data = 1'b0;
    logic          pix_ready;
    logic          det_valid_to_read;
    logic          det_detection_valid = 1'b0;
    logic          det_crossing = 1'b0;
    logic [7:0]    det_stripe_count = '0;
    logic [AW-1:0] det_bram_addr = '0;
    logic [AW-1:0] det_mark_addr = '0;
    logic          det_mark_we = 1'b0;
    logic [AW-1:0] bram_raddr;
    logic [AW-1:0] bram_waddr;
    logic [1:0]    bram_wdata;
    logic          bram_we;
    logic          busy;
    logic          result_valid;
    logic          crossing_detected;
    logic [7:0]    stripe_count;
    logic          timed_out;

    int tests = 0;
    int fails = 0;
    int cyc;
    // reference view of the latched result fields
    logic       exp_cr = 1'b0;
    logic [7:0] exp_sc = '0;
    logic       exp_to = 1'b0;

    always #5 clk = ~clk;

    zebra_frame_scheduler #(
        .IMG_WIDTH      (W),
        .IMG_HEIGHT     (H),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .start               (start),
        .abort               (abort),
        .pix_valid           (pix_valid),
        .pix_data            (pix_data),
        .pix_ready           (pix_ready),
        .det_valid_to_read   (det_valid_to_read),
        .det_detection_valid (det_detection_valid),
        .det_crossing        (det_crossing),
        .det_stripe_count    (det_stripe_count),
        .det_bram_addr       (det_bram_addr),
        .det_mark_addr       (det_mark_addr),
        .det_mark_we         (det_mark_we),
        .bram_raddr          (bram_raddr),
        .bram_waddr          (bram_waddr),
        .bram_wdata          (bram_wdata),
        .bram_we             (bram_we),
        .busy                (busy),
        .result_valid        (result_valid),
        .crossing_detected   (crossing_detected),
        .stripe_count        (stripe_count),
        .timed_out           (timed_out)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_results(input string tag);
        chk({tag, "_crossing"}, crossing_detected, exp_cr);
        chk({tag, "_stripes"}, stripe_count, exp_sc);
        chk({tag, "_timed_out"}, timed_out, exp_to);
    endtask

    // Starts a pass and streams TOTAL pixels; pct is the per-cycle chance of pix_valid.
    // Returns with the time inside the first DETECT cycle; cycles counts from the start cycle (0).
    task automatic do_load(input int pct, input bit alt, output int cycles);
        int loaded;
        loaded = 0;
        @(negedge clk); start = 1'b1; #1;
        chk("idle_before_start", busy, 0);
        @(negedge clk); start = 1'b0; cycles = 1;
        while (loaded < TOTAL && cycles < 2000) begin
            pix_valid = ($urandom_range(99) < pct);
            pix_data  = alt ? ((loaded % 2) == 0) : 1'($urandom_range(1));
            #1;
            chk("load_pix_ready", pix_ready, 1);
            chk("load_result_valid", result_valid, 0);
            chk("load_we", bram_we, pix_valid);
            if (pix_valid) begin
                chk("load_waddr", bram_waddr, loaded);
                chk("load_wdata", bram_wdata, pix_data ? PIX_WHITE : PIX_BG);
                loaded++;
            end
            @(negedge clk); cycles++;
        end
        chk("load_count", loaded, TOTAL);
        pix_valid = 1'b1; pix_data = 1'b1; #1;
        chk("settle_we", bram_we, 0);
        chk("settle_pix_ready", pix_ready, 0);
        chk("settle_armed", det_valid_to_read, 0);
        chk("settle_busy", busy, 1);
        @(negedge clk); pix_valid = 1'b0; cycles++; #1;
        chk("detect_armed", det_valid_to_read, 1);
    endtask

    // Detector model: reports (cr, sc) dly cycles after DETECT entry; dly<0 or >=TMO never reports.
    task automatic do_detect(input int dly, input logic cr, input logic [7:0] sc);
        int n;
        int exp_n;
        if (dly >= 0 && dly < TMO) begin
            exp_n = dly + 1; exp_cr = cr; exp_sc = sc; exp_to = 1'b0;
        end else begin
            exp_n = TMO; exp_cr = 1'b0; exp_sc = '0; exp_to = 1'b1;
        end
        n = 0;
        while (1) begin
            det_detection_valid = (n == dly);
            det_crossing        = (n == dly) ? cr : 1'($urandom_range(1));
            det_stripe_count    = (n == dly) ? sc : 8'($urandom_range(255));
            det_bram_addr       = AW'($urandom_range(TOTAL - 1));
            start               = (n == 2);
            #1;
            chk("detect_raddr", bram_raddr, det_bram_addr);
            @(negedge clk); #1; n++;
            if (result_valid || n >= 200) break;
        end
        start = 1'b0; det_detection_valid = 1'b0;
        chk("result_latency", n, exp_n);
        chk("done_armed", det_valid_to_read, 0);
        chk("done_busy", busy, 1);
        chk_results("done");
        @(negedge clk); #1;
        chk("post_result_valid", result_valid, 0);
        chk("post_busy", busy, 0);
        chk_results("held");
    endtask

    initial begin
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_pix_ready", pix_ready, 0);
        chk("rst_armed", det_valid_to_read, 0);
        chk("rst_we", bram_we, 0);
        chk("rst_raddr", bram_raddr, 0);
        chk("rst_waddr", bram_waddr, 0);
        chk("rst_wdata", bram_wdata, 0);
        chk("rst_result_valid", result_valid, 0);
        chk_results("rst");
        @(negedge clk); @(negedge clk); rst_n = 1'b1;

        // start and abort together: abort wins
        @(negedge clk); start = 1'b1; abort = 1'b1;
        @(negedge clk); start = 1'b0; abort = 1'b0; #1;
        chk("start_abort_idle", busy, 0);

        // fixed 1010 frame, detection 5 cycles in, visited-mark write check
        do_load(100, 1'b1, cyc);
        chk("arm_cycle", cyc, 18);
        det_mark_we = 1'b1; det_mark_addr = AW'(9); #1;
        chk("mark_we", bram_we, 1);
        chk("mark_waddr", bram_waddr, 9);
        chk("mark_wdata", bram_wdata, PIX_VISITED);
        det_mark_we = 1'b0;
        do_detect(5, 1'b1, 8'd5);

        // mark write outside DETECT is ignored
        det_mark_we = 1'b1; det_bram_addr = AW'(7); #1;
        chk("idle_mark_we", bram_we, 0);
        chk("idle_raddr", bram_raddr, 0);
        det_mark_we = 1'b0;

        // no detection: timeout
        do_load(100, 1'b0, cyc);
        do_detect(-1, 1'b0, 8'd0);

        // detection on the timeout cycle wins
        do_load(60, 1'b0, cyc);
        do_detect(TMO - 1, 1'b1, 8'd77);

        // abort on pixel 7, then a clean pass restarting at address 0
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0; pix_valid = 1'b1;
        for (int k = 0; k < 7; k++) begin
            pix_data = 1'($urandom_range(1)); #1;
            chk("abort_pre_waddr", bram_waddr, k);
            @(negedge clk);
        end
        abort = 1'b1;
        @(negedge clk); abort = 1'b0; pix_valid = 1'b0; #1;
        chk("abort_busy", busy, 0);
        chk("abort_pix_ready", pix_ready, 0);
        chk("abort_result_valid", result_valid, 0);
        chk_results("abort");
        do_load(100, 1'b1, cyc);
        do_detect(3, 1'b0, 8'd2);

        // randomized passes
        for (int r = 0; r < 4; r++) begin
            do_load($urandom_range(100, 30), 1'b0, cyc);
            do_detect($urandom_range(70), 1'($urandom_range(1)), 8'($urandom_range(255)));
        end

        // abort in DETECT coinciding with a detection: nothing latched, no pulse
        do_load(100, 1'b0, cyc);
        abort = 1'b1; det_detection_valid = 1'b1; det_crossing = ~exp_cr; det_stripe_count = ~exp_sc;
        @(negedge clk); abort = 1'b0; det_detection_valid = 1'b0; #1;
        chk("det_abort_busy", busy, 0);
        chk("det_abort_armed", det_valid_to_read, 0);
        chk("det_abort_result_valid", result_valid, 0);
        chk_results("det_abort");

        // async reset mid-DETECT clears everything immediately
        do_load(100, 1'b0, cyc);
        @(negedge clk); @(negedge clk);
        det_mark_we = 1'b1; det_mark_addr = AW'(9); det_bram_addr = AW'(5);
        rst_n = 1'b0; #1;
        exp_cr = 1'b0; exp_sc = '0; exp_to = 1'b0;
        chk("arst_busy", busy, 0);
        chk("arst_armed", det_valid_to_read, 0);
        chk("arst_we", bram_we, 0);
        chk("arst_raddr", bram_raddr, 0);
        chk("arst_waddr", bram_waddr, 0);
        chk("arst_wdata", bram_wdata, 0);
        chk_results("arst");
        @(negedge clk); det_mark_we = 1'b0; rst_n = 1'b1;
        @(negedge clk); #1;
        chk("arst_release_idle", busy, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
